// File: rtl/spi_master_pkg.sv
// Shared definitions for the SPI mode-0 master.
// Contents:
//   spi_state_e    - FSM state encoding for the master sequencer
//   SPI_CPOL       - idle level of sclk
//   accepts_wr()   - true for the states in which a new word may be loaded
package spi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEAD  = 3'd1,
        ST_XFER  = 3'd2,
        ST_CHAIN = 3'd3,
        ST_TRAIL = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

    localparam logic SPI_CPOL = 1'b0;

    function automatic logic accepts_wr(input spi_state_e st);
        return (st == ST_IDLE) || (st == ST_CHAIN);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Divider for the SPI master: counts CLK_DIV clk cycles per sclk half-period
// and emits one-cycle strobes at the end of each half-period.
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous reset, active-low
//   en        in  divider runs while high; counter and phase clear while low
//   rise_tick out strobe: the half-period ending now is followed by sclk high
//   fall_tick out strobe: the half-period ending now is followed by sclk low
// The phase starts so that the first strobe after enabling is a fall_tick;
// the master uses that first strobe to end its sclk-low setup period.
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] CNT_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          rise_next_q, rise_next_d;
    logic          tick_s;

    assign tick_s    = en && (cnt_q == CNT_LAST);
    assign rise_tick = tick_s && rise_next_q;
    assign fall_tick = tick_s && !rise_next_q;

    // Next-state for the divider counter and the rise/fall phase bit.
    always_comb begin
        cnt_d       = cnt_q;
        rise_next_d = rise_next_q;
        if (!en) begin
            cnt_d       = '0;
            rise_next_d = 1'b0;
        end else if (tick_s) begin
            cnt_d       = '0;
            rise_next_d = ~rise_next_q;
        end else begin
            cnt_d       = cnt_q + DW'(1);
            rise_next_d = rise_next_q;
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            rise_next_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rise_next_q <= rise_next_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 (CPOL=0, CPHA=0) bus master, MSB first.
// Ports:
//   clk       in  system clock, rising edge
//   rst       in  asynchronous reset, active-low
//   tx_buffer in  word to send, taken when wr && ready
//   wr        in  transfer request strobe
//   hold      in  at end of word: keep ss low for a chained word
//   ready     out a wr is accepted this cycle
//   busy      out not idle (selected, or trailing/gap delay running)
//   rx_buffer out last received word
//   rx_dv     out one-cycle pulse when rx_buffer is updated
//   sclk      out SPI clock, idles low
//   mosi      out SPI data out, 0 when idle
//   miso      in  SPI data in
//   ss        out slave select, active-low
// Sequence: IDLE -> LEAD (setup) -> XFER (WIDTH sclk pulses) -> CHAIN or
// TRAIL -> GAP -> IDLE. All outputs come straight from flops.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_buffer,
    input  logic             wr,
    input  logic             hold,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] rx_buffer,
    output logic             rx_dv,
    output logic             sclk,
    output logic             mosi,
    input  logic             miso,
    output logic             ss
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] BITS_LAST = BW'(WIDTH);

    spi_state_e       state_q, state_d;
    logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic [WIDTH-1:0] rx_buffer_q, rx_buffer_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             sclk_q, sclk_d;
    logic             ss_q, ss_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             rx_dv_q, rx_dv_d;

    logic             div_en_s;
    logic             rise_s;
    logic             fall_s;
    logic             tick_s;
    logic             accept_s;

    // The divider also times the trail and gap periods; it is held clear in
    // IDLE/CHAIN so every word starts with a full setup period.
    assign div_en_s = (state_q == ST_LEAD) || (state_q == ST_XFER) ||
                      (state_q == ST_TRAIL) || (state_q == ST_GAP);
    assign tick_s   = rise_s || fall_s;

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .en        (div_en_s),
        .rise_tick (rise_s),
        .fall_tick (fall_s)
    );

    // FSM next-state, shift registers, bit counter and output next values.
    always_comb begin
        state_d     = state_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rx_buffer_d = rx_buffer_q;
        bit_cnt_d   = bit_cnt_q;
        sclk_d      = sclk_q;
        ss_d        = ss_q;
        rx_dv_d     = 1'b0;
        accept_s    = wr && ready_q;

        case (state_q)
            ST_IDLE, ST_CHAIN: begin
                if (accept_s) begin
                    // mosi is the MSB of tx_sr, so loading presents the MSB.
                    tx_sr_d   = tx_buffer;
                    rx_sr_d   = '0;
                    bit_cnt_d = '0;
                    ss_d      = 1'b0;
                    state_d   = ST_LEAD;
                end else if ((state_q == ST_CHAIN) && !hold) begin
                    state_d = ST_TRAIL;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEAD: begin
                // First strobe only ends the setup; sclk stays low.
                if (fall_s) begin
                    state_d = ST_XFER;
                end else begin
                    state_d = state_q;
                end
            end
            ST_XFER: begin
                if (rise_s) begin
                    sclk_d    = 1'b1;
                    rx_sr_d   = {rx_sr_q[WIDTH-2:0], miso};
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end else if (fall_s) begin
                    sclk_d = 1'b0;
                    if (bit_cnt_q == BITS_LAST) begin
                        rx_buffer_d = rx_sr_q;
                        rx_dv_d     = 1'b1;
                        tx_sr_d     = '0;
                        state_d     = hold ? ST_CHAIN : ST_TRAIL;
                    end else begin
                        tx_sr_d = tx_sr_q << 1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_TRAIL: begin
                if (tick_s) begin
                    ss_d    = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    state_d = state_q;
                end
            end
            ST_GAP: begin
                if (tick_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                sclk_d  = SPI_CPOL;
                ss_d    = 1'b1;
                tx_sr_d = '0;
            end
        endcase

        ready_d = accepts_wr(state_d);
        busy_d  = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            rx_buffer_q <= '0;
            bit_cnt_q   <= '0;
            sclk_q      <= SPI_CPOL;
            ss_q        <= 1'b1;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            rx_dv_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            rx_buffer_q <= rx_buffer_d;
            bit_cnt_q   <= bit_cnt_d;
            sclk_q      <= sclk_d;
            ss_q        <= ss_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            rx_dv_q     <= rx_dv_d;
        end
    end

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign rx_buffer = rx_buffer_q;
    assign rx_dv     = rx_dv_q;
    assign sclk      = sclk_q;
    assign ss        = ss_q;
    assign mosi      = tx_sr_q[WIDTH-1];

endmodule
